// File: rtl/fifo_upsizer.sv
// Packs RATIO narrow FWFT-FIFO words into one wide word; FIFO_UPSIZER_FLUSH_EN adds flush/out_count.
// Latency: final narrow word accepted in cycle t -> out_valid from t+1; one narrow word per cycle sustained.
// Backpressure: non-final words are still popped while the output stalls; only the final word (or a flush) waits.
module fifo_upsizer #(
    parameter int IN_WIDTH  = 8,
    parameter int RATIO     = 4,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_WIDTH-1:0]        in_data,
    input  logic                       in_empty,
    output logic                       in_rd_en,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready
`ifdef FIFO_UPSIZER_FLUSH_EN
    ,
    input  logic                       flush,
    output logic [$clog2(RATIO+1)-1:0] out_count
`endif
);

    localparam int CNT_W = $clog2(RATIO);
    localparam int ACC_W = (RATIO - 1) * IN_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if (RATIO < 2 || RATIO > 16) begin : g_bad_ratio
        $error("fifo_upsizer: RATIO must be in 2..16");
    end
    if (OUT_WIDTH != IN_WIDTH * RATIO) begin : g_bad_width
        $error("fifo_upsizer: OUT_WIDTH must equal IN_WIDTH*RATIO");
    end

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 stall;
    logic                 last;
    logic                 flush_req;

`ifdef FIFO_UPSIZER_FLUSH_EN
    localparam int CW = $clog2(RATIO + 1);
    logic [CW-1:0] out_count_q, out_count_d;
    assign flush_req = flush;
    assign out_count = out_count_q;
`else
    assign flush_req = 1'b0;
`endif

    assign stall     = out_valid_q && !out_ready;
    assign last      = (cnt_q == LAST_CNT);
    // A pending flush is treated like a final word: it must not pop while the output is blocked.
    assign in_rd_en  = !in_empty && !(stall && (last || flush_req));
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef FIFO_UPSIZER_FLUSH_EN
        out_count_d = out_count_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_rd_en) begin
            if (last) begin
                out_data_d  = {in_data, acc_q};
                out_valid_d = 1'b1;
                cnt_d       = '0;
`ifdef FIFO_UPSIZER_FLUSH_EN
                out_count_d = CW'(RATIO);
`endif
            end else begin
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        acc_d[i*IN_WIDTH +: IN_WIDTH] = in_data;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef FIFO_UPSIZER_FLUSH_EN
        // cnt_d is zero whenever a full word completed, so this only fires for a true partial.
        if (flush_req && !stall && cnt_d != '0) begin
            out_data_d = '0;
            for (int i = 0; i < RATIO - 1; i++) begin
                if (CNT_W'(i) < cnt_d) begin
                    out_data_d[i*IN_WIDTH +: IN_WIDTH] = acc_d[i*IN_WIDTH +: IN_WIDTH];
                end
            end
            out_valid_d = 1'b1;
            out_count_d = CW'(cnt_d);
            cnt_d       = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef FIFO_UPSIZER_FLUSH_EN
            out_count_q <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef FIFO_UPSIZER_FLUSH_EN
            out_count_q <= out_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_upsizer.sv
// Bench for fifo_upsizer: FWFT source queue + byte-list reference model feeding a scoreboard monitor.
module tb_fifo_upsizer;

    localparam int IW = 8;
    localparam int R  = 4;
    localparam int OW = IW * R;

    typedef struct {
        logic [OW-1:0] data;
        int            cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_empty = 1'b1;
    logic          in_rd_en;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef FIFO_UPSIZER_FLUSH_EN
    logic          flush = 1'b0;
    logic [2:0]    out_count;
    logic          fl_tb = 1'b0;
`endif

    fifo_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_UPSIZER_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_words  = 0;
    logic [IW-1:0] src_q[$];
    logic [IW-1:0] model_bytes[$];
    exp_t          exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t pack(input int n);
        exp_t e;
        e.data = '0;
        for (int i = 0; i < n; i++) e.data = e.data | (OW'(model_bytes[i]) << (8 * i));
        e.cnt = n;
        return e;
    endfunction

    // Reference model: collect accepted bytes in order, emit a word every R bytes.
    task automatic model_accept(input logic [IW-1:0] b);
        model_bytes.push_back(b);
        if (model_bytes.size() == R) begin
            exp_q.push_back(pack(R));
            model_bytes.delete();
        end
    endtask

    // One cycle: drive on negedge, sample just before the next posedge.
    task automatic step(input logic rdy, input logic force_empty,
                        output logic s_rd, output logic s_ov, output logic [OW-1:0] s_od);
        @(negedge clk);
        out_ready = rdy;
        in_empty  = (src_q.size() == 0) || force_empty;
        in_data   = in_empty ? IW'($urandom) : src_q[0];
`ifdef FIFO_UPSIZER_FLUSH_EN
        flush = fl_tb;
`endif
        #4;
        s_rd = in_rd_en;
        s_ov = out_valid;
        s_od = out_data;
        if (in_rd_en) model_accept(src_q.pop_front());
`ifdef FIFO_UPSIZER_FLUSH_EN
        if (flush && !(s_ov && !rdy) && model_bytes.size() > 0) begin
            exp_q.push_back(pack(model_bytes.size()));
            model_bytes.delete();
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_empty  = 1'b1;
        out_ready = 1'b0;
        src_q.delete();
        model_bytes.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor and output-stability checker.
    logic          pv_stall = 1'b0;
    logic          pv_rst = 1'b0;
    logic [OW-1:0] pv_data = '0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && pv_rst && pv_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(pv_data));
            end
            if (rst_n && out_valid && out_ready) begin
                n_words++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 64'(out_data), 64'(e.data));
`ifdef FIFO_UPSIZER_FLUSH_EN
                    check("count", 64'(out_count), 64'(e.cnt));
`endif
                end
            end
            pv_stall = out_valid && !out_ready;
            pv_data  = out_data;
            pv_rst   = rst_n;
        end
    end

    initial begin
        logic          s_rd, s_ov;
        logic [OW-1:0] s_od;
        int            acc, w0, cyc, changed;
        logic [OW-1:0] held;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        step(1'b0, 1'b0, s_rd, s_ov, s_od);
        check("rst_valid", 64'(s_ov), 64'd0);
        check("rst_data", 64'(s_od), 64'd0);
        check("rst_rd_en", 64'(s_rd), 64'd0);

        // Single word, latency and one-cycle valid
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, s_rd, s_ov, s_od);
            acc += int'(s_rd);
        end
        check("t1_accepts", 64'(acc), 64'd4);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t1_valid", 64'(s_ov), 64'd1);
        check("t1_data", 64'(s_od), 64'h44332211);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t1_one_cycle", 64'(s_ov), 64'd0);

        // Continuous stream of two words
        for (int i = 1; i <= 8; i++) src_q.push_back(IW'(i));
        acc = 0;
        w0 = n_words;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, s_rd, s_ov, s_od);
            acc += int'(s_rd);
        end
        check("t2_rd_every_cycle", 64'(acc), 64'd8);
        repeat (2) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t2_words", 64'(n_words - w0), 64'd2);

        // Stall with the final word waiting
        src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        repeat (4) step(1'b0, 1'b0, s_rd, s_ov, s_od);
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        acc = 0;
        changed = 0;
        held = 32'hDDCCBBAA;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, s_rd, s_ov, s_od);
            acc += int'(s_rd);
            if (s_od !== held || s_ov !== 1'b1) changed++;
        end
        check("t3_partial_accepts", 64'(acc), 64'd3);
        check("t3_final_blocked", 64'(s_rd), 64'd0);
        check("t3_held_cycles_bad", 64'(changed), 64'd0);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t3_release_rd", 64'(s_rd), 64'd1);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t3_next_valid", 64'(s_ov), 64'd1);
        check("t3_next_data", 64'(s_od), 64'h04030201);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);

        // Random gaps and backpressure
        w0 = n_words;
        for (int i = 0; i < 200; i++) src_q.push_back(IW'($urandom));
        cyc = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, s_rd, s_ov, s_od);
            cyc++;
        end
        repeat (2) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t4_drained_src", 64'(src_q.size()), 64'd0);
        check("t4_drained_exp", 64'(exp_q.size()), 64'd0);
        check("t4_words", 64'(n_words - w0), 64'd50);

        // Reset in the middle of a word
        src_q = '{8'h77, 8'h88};
        repeat (2) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        do_reset();
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t5_rst_valid", 64'(s_ov), 64'd0);
        src_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        repeat (4) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t5_valid", 64'(s_ov), 64'd1);
        check("t5_data", 64'(s_od), 64'hA3A2A1A0);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);

`ifdef FIFO_UPSIZER_FLUSH_EN
        // Partial word flush, then a full word
        src_q = '{8'h55, 8'h66};
        repeat (2) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        fl_tb = 1'b1;
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        fl_tb = 1'b0;
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t6_flush_valid", 64'(s_ov), 64'd1);
        check("t6_flush_data", 64'(s_od), 64'h00006655);
        check("t6_flush_count", 64'(out_count), 64'd2);
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        repeat (4) step(1'b1, 1'b0, s_rd, s_ov, s_od);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
        check("t6_full_data", 64'(s_od), 64'h04030201);
        check("t6_full_count", 64'(out_count), 64'd4);
        step(1'b1, 1'b0, s_rd, s_ov, s_od);
`endif

        check("end_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
